addr_gap_histogram: RTL and testbench

Parametrised inter-arrival histogram monitor for the driver address path. It measures the gap in cycles between successive event pulses, such as address FIFO writes. Each gap is binned into NUM_BINS saturating counters of width 2^BIN_SHIFT, with a catch-all overflow bin, and min/max/total statistics are tracked. A snapshot shadow bank allows coherent register readout while live counting continues.

---
 rtl/drv_mon_pkg.sv | 31 +++
 rtl/drv_mon_sat_cnt.sv | 42 ++++
 rtl/addr_gap_histogram.sv | 166 ++++++++++++++++
 tb/tb_addr_gap_histogram.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/drv_mon_pkg.sv
// Shared constants and helpers for the driver-path monitors.
package drv_mon_pkg;

  localparam int unsigned DEF_NUM_BINS  = 16;
  localparam int unsigned DEF_BIN_SHIFT = 3;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_GAP_W     = 32;

  // All-ones pattern of width w (w up to 64), zero-extended to 64 bits.
  function automatic logic [63:0] all_ones(input int unsigned w);
    logic [63:0] r;
    if (w >= 32'd64) begin
      r = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      r = (64'd1 << w) - 64'd1;
    end
    return r;
  endfunction

  // Saturating increment of a w-bit value carried in 64 bits; holds at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    if (v == all_ones(w)) begin
      r = v;
    end else begin
      r = v + 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/drv_mon_sat_cnt.sv
// Width-generic saturating counter with clear (priority) and increment.
module drv_mon_sat_cnt
  import drv_mon_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then saturating increment, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(64'(cnt_q), W));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == W'(all_ones(W)));

endmodule

// File: rtl/addr_gap_histogram.sv
// Inter-arrival gap histogram with min/max/total statistics and a snapshot bank.
module addr_gap_histogram
  import drv_mon_pkg::*;
#(
  parameter int unsigned NUM_BINS  = DEF_NUM_BINS,
  parameter int unsigned BIN_SHIFT = DEF_BIN_SHIFT,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned GAP_W     = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             evt,
  input  logic             clr,
  input  logic             snap,
  input  logic [7:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [GAP_W-1:0] gap_cur,
  output logic [GAP_W-1:0] gap_min,
  output logic [GAP_W-1:0] gap_max,
  output logic [31:0]      evt_total,
  output logic             sat_any
);

  localparam int unsigned IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [GAP_W-1:0] GAP_ONES = GAP_W'(all_ones(GAP_W));

  logic [GAP_W-1:0] gap_cur_q, gap_cur_d;
  logic [GAP_W-1:0] gap_min_q, gap_min_d;
  logic [GAP_W-1:0] gap_max_q, gap_max_d;
  logic             have_prev_q, have_prev_d;
  logic             sat_any_q, sat_any_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] shadow_q [NUM_BINS];
  logic [CNT_W-1:0] shadow_d [NUM_BINS];

  logic [CNT_W-1:0]    bin_cnt [NUM_BINS];
  logic [NUM_BINS-1:0] bin_sat;
  logic                tot_sat;
  logic                bin_evt;
  logic [GAP_W-1:0]    idx_full;
  logic [IDX_W-1:0]    idx;

  // A gap is binned only when enabled, referenced, and not being cleared.
  assign bin_evt = evt & en & have_prev_q & ~clr;

  // Bin index: gap scaled by the bin width, clamped into the overflow bin.
  always_comb begin
    idx_full = gap_cur_q >> BIN_SHIFT;
    if (idx_full >= GAP_W'(NUM_BINS - 1)) begin
      idx = IDX_W'(NUM_BINS - 1);
    end else begin
      idx = IDX_W'(idx_full);
    end
  end

  for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
    drv_mon_sat_cnt #(.W(CNT_W)) u_bin (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (bin_evt && (idx == IDX_W'(i))),
      .cnt   (bin_cnt[i]),
      .sat   (bin_sat[i])
    );
  end

  drv_mon_sat_cnt #(.W(32)) u_total (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (bin_evt),
    .cnt   (evt_total),
    .sat   (tot_sat)
  );

  // Live gap counter, reference flag, min/max and sticky saturation flag.
  always_comb begin
    gap_cur_d   = gap_cur_q;
    have_prev_d = have_prev_q;
    gap_min_d   = gap_min_q;
    gap_max_d   = gap_max_q;
    sat_any_d   = sat_any_q;
    if (evt) begin
      gap_cur_d = GAP_W'(1);
    end else if (clr) begin
      gap_cur_d = '0;
    end else begin
      gap_cur_d = GAP_W'(sat_inc(64'(gap_cur_q), GAP_W));
    end
    if (clr) begin
      have_prev_d = 1'b0;
      gap_min_d   = GAP_ONES;
      gap_max_d   = '0;
      sat_any_d   = 1'b0;
    end else begin
      have_prev_d = have_prev_q | evt;
      sat_any_d   = sat_any_q | (|bin_sat) | tot_sat;
      if (bin_evt) begin
        if (gap_cur_q < gap_min_q) begin
          gap_min_d = gap_cur_q;
        end else begin
          gap_min_d = gap_min_q;
        end
        if (gap_cur_q > gap_max_q) begin
          gap_max_d = gap_cur_q;
        end else begin
          gap_max_d = gap_max_q;
        end
      end else begin
        gap_min_d = gap_min_q;
        gap_max_d = gap_max_q;
      end
    end
  end

  // Shadow bank captures pre-update live bins; clr does not touch it.
  always_comb begin
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = bin_cnt;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow readout mux; selects past the last bin read as zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_sel} < 9'(NUM_BINS)) begin
      rd_data_d = shadow_q[rd_sel[IDX_W-1:0]];
    end else begin
      rd_data_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_cur_q   <= '0;
      gap_min_q   <= GAP_ONES;
      gap_max_q   <= '0;
      have_prev_q <= 1'b0;
      sat_any_q   <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      gap_cur_q   <= gap_cur_d;
      gap_min_q   <= gap_min_d;
      gap_max_q   <= gap_max_d;
      have_prev_q <= have_prev_d;
      sat_any_q   <= sat_any_d;
      rd_data_q   <= rd_data_d;
      shadow_q    <= shadow_d;
    end
  end

  assign rd_data = rd_data_q;
  assign gap_cur = gap_cur_q;
  assign gap_min = gap_min_q;
  assign gap_max = gap_max_q;
  assign sat_any = sat_any_q;

endmodule

// File: tb/tb_addr_gap_histogram.sv
// Directed self-checking bench for addr_gap_histogram (default and narrow-counter builds).
module tb_addr_gap_histogram;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        evt = 1'b0;
  logic        clr = 1'b0;
  logic        snap = 1'b0;
  logic [7:0]  rd_sel = 8'd0;

  logic [15:0] rd_data;
  logic [31:0] gap_cur, gap_min, gap_max, evt_total;
  logic        sat_any;

  logic [3:0]  rd_data_n;
  logic [31:0] gap_cur_n, gap_min_n, gap_max_n, evt_total_n;
  logic        sat_any_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_gap_histogram dut (
    .clk(clk), .reset(reset), .en(en), .evt(evt), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd_data), .gap_cur(gap_cur), .gap_min(gap_min),
    .gap_max(gap_max), .evt_total(evt_total), .sat_any(sat_any)
  );

  addr_gap_histogram #(.CNT_W(4)) dut_n (
    .clk(clk), .reset(reset), .en(en), .evt(evt), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(rd_data_n), .gap_cur(gap_cur_n), .gap_min(gap_min_n),
    .gap_max(gap_max_n), .evt_total(evt_total_n), .sat_any(sat_any_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic evt_pulse();
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  // Next event lands exactly k cycles after the previous one.
  task automatic send_gap(input int k);
    repeat (k - 1) tick();
    evt_pulse();
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic read_sel(input logic [7:0] s);
    rd_sel = s;
    tick();
  endtask

  initial begin
    // ---- Test 1: reset values and uniform gap of 5 ----
    en = 1'b1;
    do_reset();
    reset = 1'b0;
    tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_gap_cur", gap_cur, 0);
    check("rst_gap_min", gap_min, 32'hFFFF_FFFF);
    check("rst_gap_max", gap_max, 0);
    check("rst_evt_total", evt_total, 0);
    check("rst_sat_any", sat_any, 0);
    reset = 1'b1;
    evt_pulse();
    check("t1_unbinned_first", evt_total, 0);
    repeat (9) send_gap(5);
    check("t1_gap_cur", gap_cur, 1);
    check("t1_total", evt_total, 9);
    check("t1_min", gap_min, 5);
    check("t1_max", gap_max, 5);
    do_snap();
    for (int s = 0; s < 16; s++) begin
      read_sel(8'(s));
      check($sformatf("t1_bin%0d", s), rd_data, (s == 0) ? 9 : 0);
    end

    // ---- Test 2: spread of gaps across bins and overflow ----
    do_reset();
    evt_pulse();
    send_gap(1);
    send_gap(7);
    send_gap(8);
    send_gap(15);
    send_gap(16);
    send_gap(119);
    send_gap(120);
    send_gap(5000);
    check("t2_total", evt_total, 8);
    check("t2_min", gap_min, 1);
    check("t2_max", gap_max, 5000);
    do_snap();
    read_sel(8'd0);  check("t2_bin0", rd_data, 2);
    read_sel(8'd1);  check("t2_bin1", rd_data, 2);
    read_sel(8'd2);  check("t2_bin2", rd_data, 1);
    read_sel(8'd3);  check("t2_bin3", rd_data, 0);
    read_sel(8'd13); check("t2_bin13", rd_data, 0);
    read_sel(8'd14); check("t2_bin14", rd_data, 1);
    read_sel(8'd15); check("t2_bin15", rd_data, 2);

    // ---- Test 3: 4-bit bins saturate at 15 ----
    do_reset();
    evt_pulse();
    repeat (14) send_gap(3);
    check("t3_no_sat_yet", sat_any_n, 0);
    repeat (3) send_gap(3);
    tick();
    check("t3_sat_any", sat_any_n, 1);
    check("t3_total", evt_total_n, 17);
    check("t3_wide_no_sat", sat_any, 0);
    do_snap();
    read_sel(8'd0);
    check("t3_bin0_sat", rd_data_n, 15);
    check("t3_bin0_wide", rd_data, 17);

    // ---- Test 4: snap coincident with a binning event ----
    do_reset();
    evt_pulse();
    repeat (4) send_gap(3);
    tick();
    tick();
    evt = 1'b1;
    snap = 1'b1;
    tick();
    evt = 1'b0;
    snap = 1'b0;
    read_sel(8'd0);
    check("t4_shadow_pre", rd_data, 4);
    do_snap();
    read_sel(8'd0);
    check("t4_shadow_post", rd_data, 5);
    read_sel(8'd200);
    check("t4_sel_oob", rd_data, 0);

    // ---- Test 5: clr coincident with evt ----
    tick();
    clr = 1'b1;
    evt = 1'b1;
    tick();
    clr = 1'b0;
    evt = 1'b0;
    check("t5_clr_total", evt_total, 0);
    check("t5_clr_min", gap_min, 32'hFFFF_FFFF);
    check("t5_clr_max", gap_max, 0);
    check("t5_clr_gap_cur", gap_cur, 1);
    send_gap(6);
    check("t5_unbinned", evt_total, 0);
    send_gap(6);
    check("t5_total", evt_total, 1);
    check("t5_min", gap_min, 6);
    check("t5_max", gap_max, 6);
    read_sel(8'd0);
    check("t5_shadow_kept", rd_data, 5);
    do_snap();
    read_sel(8'd0);
    check("t5_bin0", rd_data, 1);

    // ---- Test 6: en low freezes statistics; mid-run reset ----
    do_reset();
    en = 1'b0;
    evt_pulse();
    send_gap(3);
    send_gap(3);
    check("t6_frozen", evt_total, 0);
    en = 1'b1;
    send_gap(4);
    check("t6_total", evt_total, 1);
    check("t6_min", gap_min, 4);
    check("t6_max", gap_max, 4);
    do_snap();
    read_sel(8'd0);
    check("t6_bin0", rd_data, 1);
    send_gap(2);
    reset = 1'b0;
    tick();
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_gap_cur", gap_cur, 0);
    check("t6_rst_gap_min", gap_min, 32'hFFFF_FFFF);
    check("t6_rst_gap_max", gap_max, 0);
    check("t6_rst_total", evt_total, 0);
    check("t6_rst_sat", sat_any, 0);
    reset = 1'b1;
    do_snap();
    read_sel(8'd0);
    check("t6_rst_shadow", rd_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
